// File: rtl/dma_pkg.sv
// Shared types for the DMA write/end-program ordering queue.
// Holds the write request bundle and its field widths.
package dma_pkg;

  localparam int DMA_ADDR_W = 16;
  localparam int DMA_TILE_W = 18 * 16;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0] addr;
    logic [DMA_TILE_W-1:0] tile;
  } dma_write_req_t;

endpackage

// File: rtl/dma_write_order_queue_if.sv
// Push/pop bundle of the DMA write ordering queue.
// slave: the queue itself; master: issue logic plus packet sender.
interface dma_write_order_queue_if;
  import dma_pkg::*;

  logic                  wr_valid;
  logic                  wr_ready;
  logic [DMA_ADDR_W-1:0] wr_addr;
  logic [DMA_TILE_W-1:0] wr_tile;
  logic                  ep_valid;
  logic                  ep_ready;

  logic [DMA_ADDR_W-1:0] dma_send_write_queue_data;
  logic [DMA_TILE_W-1:0] dma_send_write_queue_data2;
  logic                  dma_send_write_queue_available;
  logic                  dma_send_write_queue_re;
  logic                  dma_send_end_program_queue_available;
  logic                  dma_send_end_program_queue_re;
  logic                  underflow_err;

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_tile,
    input  ep_valid,
    input  dma_send_write_queue_re,
    input  dma_send_end_program_queue_re,
    output wr_ready,
    output ep_ready,
    output dma_send_write_queue_data,
    output dma_send_write_queue_data2,
    output dma_send_write_queue_available,
    output dma_send_end_program_queue_available,
    output underflow_err
  );

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_tile,
    output ep_valid,
    output dma_send_write_queue_re,
    output dma_send_end_program_queue_re,
    input  wr_ready,
    input  ep_ready,
    input  dma_send_write_queue_data,
    input  dma_send_write_queue_data2,
    input  dma_send_write_queue_available,
    input  dma_send_end_program_queue_available,
    input  underflow_err
  );

endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; dout is storage[rd_ptr].
// Ports: clk, resetn, push, pop, din, dout, full, empty, count.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Power-of-two depth: pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage carries no reset; validity lives in cnt_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/dma_write_order_queue.sv
// Orders DMA writes against end-program markers for the packet sender.
// Ports: clk, resetn, q (slave bundle: push side, FWFT pop side, underflow_err).
module dma_write_order_queue
  import dma_pkg::*;
#(
  parameter int WR_DEPTH = 4,
  parameter int EP_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  dma_write_order_queue_if.slave  q
);

  localparam int SEQ_W = $clog2(WR_DEPTH) + 1;
  localparam int WCW   = $clog2(WR_DEPTH) + 1;
  localparam int ECW   = $clog2(EP_DEPTH) + 1;

  logic             rdy_q, rdy_d;
  logic [SEQ_W-1:0] wr_seq_q, wr_seq_d;
  logic [SEQ_W-1:0] rd_seq_q, rd_seq_d;
  logic             uf_q, uf_d;

  dma_write_req_t   wr_din;
  dma_write_req_t   wr_head;
  logic             wr_full, wr_empty;
  logic [WCW-1:0]   wr_count;
  logic [SEQ_W-1:0] ep_head;
  logic             ep_full, ep_empty;
  logic [ECW-1:0]   ep_count;

  logic wr_ready_w, ep_ready_w;
  logic wr_push, ep_push;
  logic wr_pop, ep_pop;
  logic ep_block, wr_avail;
  logic cnt_unused;

  // Ready stays low until the first edge after reset release.
  assign wr_ready_w = rdy_q && !wr_full;
  assign ep_ready_w = rdy_q && !ep_full;
  assign wr_push    = q.wr_valid && wr_ready_w;
  assign ep_push    = q.ep_valid && ep_ready_w;

  // Head marker is due once every write before it has been popped.
  assign ep_block = !ep_empty && (rd_seq_q == ep_head);
  assign wr_avail = !wr_empty && !ep_block;
  assign wr_pop   = q.dma_send_write_queue_re && wr_avail;
  assign ep_pop   = q.dma_send_end_program_queue_re && ep_block;

  assign wr_din.addr = q.wr_addr;
  assign wr_din.tile = q.wr_tile;

  always_comb begin
    rdy_d    = 1'b1;
    wr_seq_d = wr_seq_q + SEQ_W'(wr_push);
    rd_seq_d = rd_seq_q + SEQ_W'(wr_pop);
    uf_d     = uf_q;
    if (q.dma_send_write_queue_re && !wr_avail) begin
      uf_d = 1'b1;
    end
    if (q.dma_send_end_program_queue_re && !ep_block) begin
      uf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdy_q    <= 1'b0;
      wr_seq_q <= '0;
      rd_seq_q <= '0;
      uf_q     <= 1'b0;
    end else begin
      rdy_q    <= rdy_d;
      wr_seq_q <= wr_seq_d;
      rd_seq_q <= rd_seq_d;
      uf_q     <= uf_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH ($bits(dma_write_req_t)),
    .DEPTH (WR_DEPTH)
  ) u_wr_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (wr_push),
    .pop    (wr_pop),
    .din    (wr_din),
    .dout   (wr_head),
    .full   (wr_full),
    .empty  (wr_empty),
    .count  (wr_count)
  );

  // Snapshot uses post-push wr_seq: a same-cycle write precedes the marker.
  sync_fifo_fwft #(
    .WIDTH (SEQ_W),
    .DEPTH (EP_DEPTH)
  ) u_ep_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (ep_push),
    .pop    (ep_pop),
    .din    (wr_seq_d),
    .dout   (ep_head),
    .full   (ep_full),
    .empty  (ep_empty),
    .count  (ep_count)
  );

  assign cnt_unused = ^{wr_count, ep_count};

  assign q.wr_ready                             = wr_ready_w;
  assign q.ep_ready                             = ep_ready_w;
  assign q.dma_send_write_queue_data            = wr_head.addr;
  assign q.dma_send_write_queue_data2           = wr_head.tile;
  assign q.dma_send_write_queue_available       = wr_avail;
  assign q.dma_send_end_program_queue_available = ep_block;
  assign q.underflow_err                        = uf_q;

endmodule

// File: tb/tb_dma_write_order_queue.sv
// Bench for dma_write_order_queue against a single ordered item queue.
// Directed scenarios followed by a randomized phase.
module tb_dma_write_order_queue;
  import dma_pkg::*;

  localparam int WD = 4;
  localparam int ED = 4;

  typedef struct {
    bit          ep;
    logic [15:0] a;
    logic [287:0] t;
  } item_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  dma_write_order_queue_if bus ();

  dma_write_order_queue #(
    .WR_DEPTH (WD),
    .EP_DEPTH (ED)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .q      (bus)
  );

  // Model: one queue in delivery order; the front item is the only
  // poppable one, whatever kind it is.
  item_t mq[$];
  int    m_wr;
  int    m_ep;
  bit    m_rdy;
  bit    m_uf;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  logic [287:0] t1;

  function automatic bit m_wa();
    return mq.size() > 0 && !mq[0].ep;
  endfunction

  function automatic bit m_ea();
    return mq.size() > 0 && mq[0].ep;
  endfunction

  function automatic logic [287:0] rtile();
    logic [287:0] r;
    for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [287:0] got,
                     input logic [287:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_wr  = 0;
    m_ep  = 0;
    m_rdy = 0;
    m_uf  = 0;
  endtask

  task automatic cyc(input bit wv, input logic [15:0] a,
                     input logic [287:0] t, input bit ev,
                     input bit wre, input bit ere);
    bit ew, ee, wa, ea;
    item_t it;
    bus.wr_valid                      = wv;
    bus.wr_addr                       = a;
    bus.wr_tile                       = t;
    bus.ep_valid                      = ev;
    bus.dma_send_write_queue_re       = wre;
    bus.dma_send_end_program_queue_re = ere;
    #1;
    ew = m_rdy && (m_wr < WD);
    ee = m_rdy && (m_ep < ED);
    wa = m_wa();
    ea = m_ea();
    chk("wr_ready", bus.wr_ready, ew);
    chk("ep_ready", bus.ep_ready, ee);
    chk("wr_avail", bus.dma_send_write_queue_available, wa);
    chk("ep_avail", bus.dma_send_end_program_queue_available, ea);
    chk("underflow", bus.underflow_err, m_uf);
    if (wa) begin
      chk("head_addr", bus.dma_send_write_queue_data, mq[0].a);
      chk("head_tile", bus.dma_send_write_queue_data2, mq[0].t);
    end
    @(posedge clk);
    if (resetn) begin
      if ((wre && !wa) || (ere && !ea)) m_uf = 1;
      if ((wre && wa) || (ere && ea)) begin
        if (mq[0].ep) m_ep--;
        else m_wr--;
        void'(mq.pop_front());
      end
      if (wv && ew) begin
        it.ep = 0; it.a = a; it.t = t;
        mq.push_back(it);
        m_wr++;
      end
      if (ev && ee) begin
        it.ep = 1; it.a = '0; it.t = '0;
        mq.push_back(it);
        m_ep++;
      end
      m_rdy = 1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 16'h0, '0, 0, 0, 0);
  endtask

  task automatic wr(input logic [15:0] a);
    cyc(1, a, rtile(), 0, 0, 0);
  endtask

  // Asserts reset mid-cycle and checks outputs drop without a clock edge.
  task automatic async_reset();
    resetn = 1'b0;
    #1;
    chk("rst_wr_avail", bus.dma_send_write_queue_available, 1'b0);
    chk("rst_ep_avail", bus.dma_send_end_program_queue_available, 1'b0);
    chk("rst_wr_ready", bus.wr_ready, 1'b0);
    chk("rst_ep_ready", bus.ep_ready, 1'b0);
    chk("rst_underflow", bus.underflow_err, 1'b0);
    model_clear();
    @(negedge clk);
    idle();
    resetn = 1'b1;
    idle();
  endtask

  initial begin
    model_clear();
    resetn = 1'b0;
    idle();
    idle();
    resetn = 1'b1;
    idle();

    // 1: single write, FWFT pop
    for (int i = 0; i < 36; i++) t1[287 - 8*i -: 8] = 8'(i + 1);
    cyc(1, 16'h0010, t1, 0, 0, 0);
    chk("t1_msb_byte", bus.dma_send_write_queue_data2[287:280], 8'h01);
    cyc(0, 16'h0, '0, 0, 1, 0);
    idle();

    // 2: W0, W1, EP, W2
    wr(16'h0100);
    wr(16'h0101);
    cyc(0, 16'h0, '0, 1, 0, 0);
    wr(16'h0102);
    cyc(0, 16'h0, '0, 0, 1, 0);
    cyc(0, 16'h0, '0, 0, 1, 0);
    idle();
    cyc(0, 16'h0, '0, 0, 0, 1);
    cyc(0, 16'h0, '0, 0, 1, 0);
    idle();

    // 3: fill, push+pop while full, then 5th write
    for (int i = 0; i < WD; i++) wr(16'h0200 + 16'(i));
    cyc(1, 16'h02ee, rtile(), 0, 1, 0);
    cyc(1, 16'h0204, rtile(), 0, 0, 0);
    for (int i = 0; i < WD; i++) cyc(0, 16'h0, '0, 0, 1, 0);
    idle();

    // 4: marker on empty write FIFO, then two back-to-back markers
    cyc(0, 16'h0, '0, 1, 0, 0);
    idle();
    cyc(0, 16'h0, '0, 0, 0, 1);
    cyc(0, 16'h0, '0, 1, 0, 0);
    cyc(0, 16'h0, '0, 1, 0, 0);
    cyc(0, 16'h0, '0, 0, 0, 1);
    idle();
    cyc(0, 16'h0, '0, 0, 0, 1);
    idle();

    // 5: 20 writes, marker alongside every third, legal pops only
    for (int i = 0; i < 20; i++)
      cyc(1, 16'h0300 + 16'(i), rtile(), (i % 3) == 2,
          m_wa() && (i % 2 == 1), m_ea());
    for (int i = 0; i < 40 && mq.size() > 0; i++)
      cyc(0, 16'h0, '0, 0, m_wa(), m_ea());
    idle();

    // random phase: any mix of pushes and pops, legal or not
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(0, 2) != 0, 16'($urandom), rtile(),
          $urandom_range(0, 4) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);

    // 6: sticky underflow, then async reset with entries held
    async_reset();
    cyc(0, 16'h0, '0, 0, 1, 0);
    idle();
    idle();
    wr(16'h0400);
    wr(16'h0401);
    cyc(0, 16'h0, '0, 1, 0, 0);
    async_reset();
    idle();
    cyc(0, 16'h0, '0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
